// File: rtl/softmax_ru_ctrl.sv
// softmax_ru_ctrl: two-pass softmax sequencer driving one RU reduction unit.
// Define SOFTMAX_CTRL_PERF_EN to add o_cycles, a first-beat to m_last latency counter.
module softmax_ru_ctrl #(
    parameter int N = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        m_last,
    output logic        o_ru_en,
    output logic        o_ru_sel_mult,
    output logic        o_ru_sel_mux,
    output logic        o_ru_valid,
    output logic [31:0] o_ru_in0,
    output logic [15:0] o_ru_in1,
    input  logic        i_ru_valid,
    input  logic [15:0] i_ru_out0,
    input  logic [15:0] i_ru_out1
`ifdef SOFTMAX_CTRL_PERF_EN
    ,
    output logic [15:0] o_cycles
`endif
);
    localparam int CW = $clog2(N) + 1;
    localparam int IW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ISSUE1 = 3'd2,
        DRAIN1 = 3'd3,
        ISSUE2 = 3'd4,
        DRAIN2 = 3'd5
    } state_t;

    state_t        state_r, state_s;
    logic [15:0]   buf_r [N];
    logic [15:0]   max_r;
    logic [31:0]   sum_r;
    logic [CW-1:0] wr_idx_r, rd_idx_r, ret_idx_r;
    logic          s_ready_r;
    logic          ru_valid_r, ru_sel_mult_r, ru_sel_mux_r;
    logic [31:0]   ru_in0_r;
    logic [15:0]   ru_in1_r;

    logic pass1_s, pass2_s, ru_en_s, in_fire_s, issue_s, ret1_s;
    logic m_valid_s, out_fire_s, ret_last_s;

    // Phase and handshake decode shared by the FSM and datapath.
    always_comb begin
        pass1_s = (state_r == ISSUE1) || (state_r == DRAIN1);
        pass2_s = (state_r == ISSUE2) || (state_r == DRAIN2);
        // In pass 2 the RU pipeline doubles as the output skid: freeze it on backpressure.
        if (pass2_s) begin
            ru_en_s = m_ready;
        end else begin
            ru_en_s = 1'b1;
        end
        in_fire_s  = s_valid && s_ready_r;
        issue_s    = ((state_r == ISSUE1) || (state_r == ISSUE2)) && ru_en_s;
        ret1_s     = pass1_s && i_ru_valid;
        m_valid_s  = pass2_s && i_ru_valid;
        out_fire_s = m_valid_s && m_ready;
        ret_last_s = (ret_idx_r == LAST);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (in_fire_s) state_s = LOAD; else state_s = IDLE;
            LOAD:    if (in_fire_s && (wr_idx_r == LAST)) state_s = ISSUE1; else state_s = LOAD;
            ISSUE1:  if (issue_s && (rd_idx_r == LAST)) state_s = DRAIN1; else state_s = ISSUE1;
            DRAIN1:  if (ret1_s && ret_last_s) state_s = ISSUE2; else state_s = DRAIN1;
            ISSUE2:  if (issue_s && (rd_idx_r == LAST)) state_s = DRAIN2; else state_s = ISSUE2;
            DRAIN2:  if (out_fire_s && ret_last_s) state_s = IDLE; else state_s = DRAIN2;
            default: state_s = IDLE;
        endcase
    end

    // State register and registered input-ready.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= IDLE;
            s_ready_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            s_ready_r <= (state_s == IDLE) || (state_s == LOAD);
        end
    end

    // Vector buffer: loaded with scores, overwritten in place by pass-1 y values.
    always_ff @(posedge i_clk) begin
        if (in_fire_s) begin
            buf_r[wr_idx_r[IW-1:0]] <= s_data;
        end else if (ret1_s) begin
            buf_r[ret_idx_r[IW-1:0]] <= i_ru_out0;
        end
    end

    // Counters, running max and exponent sum.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_idx_r  <= ZERO;
            rd_idx_r  <= ZERO;
            ret_idx_r <= ZERO;
            max_r     <= 16'h0000;
            sum_r     <= 32'h0000_0000;
        end else begin
            if (in_fire_s) begin
                wr_idx_r <= (wr_idx_r == LAST) ? ZERO : wr_idx_r + ONE;
                if (state_r == IDLE) begin
                    max_r <= s_data;
                    sum_r <= 32'h0000_0000;
                end else if ($signed(s_data) > $signed(max_r)) begin
                    max_r <= s_data;
                end
            end
            if (issue_s) begin
                rd_idx_r <= (rd_idx_r == LAST) ? ZERO : rd_idx_r + ONE;
            end
            if (ret1_s || out_fire_s) begin
                ret_idx_r <= ret_last_s ? ZERO : ret_idx_r + ONE;
            end
            if (ret1_s) begin
                sum_r <= sum_r + {16'h0000, i_ru_out1};
            end
        end
    end

    // Registered RU issue port; holds while the RU is frozen.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ru_valid_r    <= 1'b0;
            ru_sel_mult_r <= 1'b0;
            ru_sel_mux_r  <= 1'b0;
            ru_in0_r      <= 32'h0000_0000;
            ru_in1_r      <= 16'h0000;
        end else if (ru_en_s) begin
            ru_valid_r <= issue_s;
            if (issue_s) begin
                ru_sel_mult_r <= (state_r == ISSUE1);
                ru_sel_mux_r  <= (state_r == ISSUE1);
                ru_in0_r      <= (state_r == ISSUE1) ? {{16{max_r[15]}}, max_r} : sum_r;
                ru_in1_r      <= buf_r[rd_idx_r[IW-1:0]];
            end
        end
    end

`ifdef SOFTMAX_CTRL_PERF_EN
    logic [15:0] run_cnt_r, cycles_r;

    // Latency counter: starts on the first beat, captured on the m_last handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            run_cnt_r <= 16'h0000;
            cycles_r  <= 16'h0000;
        end else begin
            if (in_fire_s && (state_r == IDLE)) begin
                run_cnt_r <= 16'h0001;
            end else if ((state_r != IDLE) && (run_cnt_r != 16'hFFFF)) begin
                run_cnt_r <= run_cnt_r + 16'h0001;
            end
            if (out_fire_s && ret_last_s) begin
                cycles_r <= run_cnt_r;
            end
        end
    end

    assign o_cycles = cycles_r;
`endif

    assign s_ready       = s_ready_r;
    assign m_valid       = m_valid_s;
    assign m_data        = m_valid_s ? i_ru_out1 : 16'h0000;
    assign m_last        = m_valid_s && ret_last_s;
    assign o_ru_en       = ru_en_s;
    assign o_ru_valid    = ru_valid_r;
    assign o_ru_sel_mult = ru_sel_mult_r;
    assign o_ru_sel_mux  = ru_sel_mux_r;
    assign o_ru_in0      = ru_in0_r;
    assign o_ru_in1      = ru_in1_r;
endmodule

// File: tb/tb_softmax_ru_ctrl.sv
// Bench for softmax_ru_ctrl: behavioural RU (11-stage, real arithmetic) plus a softmax reference.
module tb_softmax_ru_ctrl;
    localparam int N = 4;
    localparam int L = 11;
    localparam int BUDGET = 400;

    typedef logic [0:N-1][15:0] vec_t;
    typedef struct {
        vec_t sc;
        vec_t ex;
    } tv_t;

    logic        i_clk, i_rst;
    logic        s_valid, s_ready, m_valid, m_ready, m_last;
    logic [15:0] s_data, m_data;
    logic        o_ru_en, o_ru_sel_mult, o_ru_sel_mux, o_ru_valid;
    logic [31:0] o_ru_in0;
    logic [15:0] o_ru_in1;
    logic        ru_valid;
    logic [15:0] ru_out0, ru_out1;
`ifdef SOFTMAX_CTRL_PERF_EN
    logic [15:0] o_cycles;
`endif

    softmax_ru_ctrl #(.N(N)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .o_ru_en(o_ru_en), .o_ru_sel_mult(o_ru_sel_mult), .o_ru_sel_mux(o_ru_sel_mux),
        .o_ru_valid(o_ru_valid), .o_ru_in0(o_ru_in0), .o_ru_in1(o_ru_in1),
        .i_ru_valid(ru_valid), .i_ru_out0(ru_out0), .i_ru_out1(ru_out1)
`ifdef SOFTMAX_CTRL_PERF_EN
        , .o_cycles(o_cycles)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // RU arithmetic in real numbers, quantised to Q6.10.
    function automatic int rnd_q10(real a);
        real s;
        int  q;
        s = a * 1024.0;
        if (s > 40000.0) s = 40000.0;
        if (s < -40000.0) s = -40000.0;
        if (s >= 0.0) q = $rtoi(s + 0.5);
        else q = -$rtoi(0.5 - s);
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    function automatic int ru_arg(logic [31:0] in0, logic [15:0] in1, logic mult, logic mux);
        real a;
        a = $itor($signed(in1)) / 1024.0;
        if (mux) a = a - $itor($signed(in0)) / 1024.0;
        else if (in0 == 32'd0) a = a - 64.0;
        else a = a - $ln($itor(in0) / 1024.0) / $ln(2.0);
        if (mult) a = a * 1.4426950408889634;
        return rnd_q10(a);
    endfunction

    function automatic int ru_pow(int y);
        real p;
        p = (2.0 ** ($itor(y) / 1024.0)) * 1024.0;
        if (p > 65535.0) return 65535;
        return $rtoi(p + 0.5);
    endfunction

    // Softmax straight from the two-pass definition.
    function automatic vec_t model(vec_t v);
        logic [15:0] mx;
        logic [31:0] sum;
        int          y [N];
        vec_t        e;
        mx = v[0];
        for (int i = 1; i < N; i++) if ($signed(v[i]) > $signed(mx)) mx = v[i];
        sum = 32'd0;
        for (int i = 0; i < N; i++) begin
            y[i] = ru_arg({{16{mx[15]}}, mx}, v[i], 1'b1, 1'b1);
            sum  = sum + 32'(ru_pow(y[i]));
        end
        for (int i = 0; i < N; i++) e[i] = 16'(ru_pow(ru_arg(sum, 16'(y[i]), 1'b0, 1'b0)));
        return e;
    endfunction

    // Behavioural RU: L-stage pipeline advancing only on enabled cycles.
    logic        pv [L];
    logic [15:0] p0 [L];
    logic [15:0] p1 [L];
    always @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < L; i++) begin
                pv[i] <= 1'b0;
                p0[i] <= 16'h0000;
                p1[i] <= 16'h0000;
            end
        end else if (o_ru_en) begin
            pv[0] <= o_ru_valid;
            p0[0] <= 16'(ru_arg(o_ru_in0, o_ru_in1, o_ru_sel_mult, o_ru_sel_mux));
            p1[0] <= 16'(ru_pow(ru_arg(o_ru_in0, o_ru_in1, o_ru_sel_mult, o_ru_sel_mux)));
            for (int i = 1; i < L; i++) begin
                pv[i] <= pv[i-1];
                p0[i] <= p0[i-1];
                p1[i] <= p1[i-1];
            end
        end
    end
    assign ru_valid = pv[L-1];
    assign ru_out0  = p0[L-1];
    assign ru_out1  = p1[L-1];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    logic [15:0]  got_q [$];
    logic [N-1:0] last_bits;
    int           latency;
    bit           sready_bad;

    // mode 0: m_ready high; 1: 5-cycle stall at first m_valid; 2: random m_ready.
    task automatic run_vector(input vec_t v, input int mode);
        int sent, cyc, acc_cyc, first_cyc, stall;
        bit done;
        sent = 0; cyc = 0; acc_cyc = -1; first_cyc = -1; stall = 0; done = 1'b0;
        got_q.delete();
        last_bits = '0;
        sready_bad = 1'b0;
        while (!done && cyc < BUDGET) begin
            @(negedge i_clk);
            if (sent < N) begin
                s_valid = 1'b1;
                s_data  = v[sent];
            end else begin
                s_valid = 1'b0;
                s_data  = 16'h0000;
            end
            case (mode)
                1: begin
                    if (m_valid && first_cyc < 0) stall = 5;
                    if (stall > 0) begin
                        m_ready = 1'b0;
                        stall--;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
                2: m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b1;
            endcase
            #1;
            if (m_valid && first_cyc < 0) first_cyc = cyc;
            if (mode == 1 && !m_ready)
                chk("stall_hold", {14'h0, m_valid, o_ru_en, m_data}, {14'h0, 1'b1, 1'b0, 16'h0100});
            if (acc_cyc >= 0 && cyc > acc_cyc && s_ready) sready_bad = 1'b1;
            if (s_valid && s_ready) begin
                sent++;
                if (sent == N) acc_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                last_bits = {last_bits[N-2:0], m_last};
                if (m_last || got_q.size() >= N + 2) done = 1'b1;
            end
            cyc++;
        end
        latency = first_cyc - acc_cyc;
        chk("timeout", {31'h0, done}, 32'h1);
    endtask

    task automatic check_outputs(input string tag, input vec_t ex);
        chk({tag, "_count"}, got_q.size(), N);
        for (int k = 0; k < N; k++)
            chk($sformatf("%s_out%0d", tag, k),
                (k < got_q.size()) ? {16'h0, got_q[k]} : 32'hFFFF_FFFF, {16'h0, ex[k]});
        chk({tag, "_last"}, {28'h0, last_bits}, 32'h1);
    endtask

    task automatic load_only(input vec_t v);
        int sent = 0;
        int cyc = 0;
        while (sent < N && cyc < BUDGET) begin
            @(negedge i_clk);
            s_valid = 1'b1;
            s_data  = v[sent];
            #1;
            if (s_ready) sent++;
            cyc++;
        end
        @(negedge i_clk);
        s_valid = 1'b0;
        s_data  = 16'h0000;
        chk("load_done", sent, N);
    endtask

    tv_t  tbl [6];
    vec_t zeros, v3, e3, rv, ev;
`ifdef SOFTMAX_CTRL_PERF_EN
    logic [15:0] cyc1, cyc2;
`endif

    initial begin
        zeros = {4{16'h0000}};
        tbl[0].sc = zeros;                                        tbl[0].ex = {4{16'h0100}};
        tbl[1].sc = {4{16'h0800}};                                tbl[1].ex = {4{16'h0100}};
        tbl[2].sc = {4{16'hF400}};                                tbl[2].ex = {4{16'h0100}};
        tbl[3].sc = {16'h2000, 16'hE000, 16'hE000, 16'hE000};     tbl[3].ex = {16'h0400, 16'h0000, 16'h0000, 16'h0000};
        tbl[4].sc = {16'hE000, 16'hE000, 16'h2000, 16'hE000};     tbl[4].ex = {16'h0000, 16'h0000, 16'h0400, 16'h0000};
        tbl[5].sc = {16'h2000, 16'hE000, 16'h2000, 16'hE000};     tbl[5].ex = {16'h0200, 16'h0000, 16'h0200, 16'h0000};

        i_rst = 1'b1; s_valid = 1'b0; s_data = 16'h0000; m_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("rst_s_ready", {31'h0, s_ready}, 32'h0);
        chk("rst_m_out", {13'h0, m_valid, m_last, o_ru_en, m_data}, {13'h0, 1'b0, 1'b0, 1'b1, 16'h0000});
        chk("rst_ru_ctl", {29'h0, o_ru_valid, o_ru_sel_mult, o_ru_sel_mux}, 32'h0);
        chk("rst_ru_in0", o_ru_in0, 32'h0);
        chk("rst_ru_in1", {16'h0, o_ru_in1}, 32'h0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_s_ready", {31'h0, s_ready}, 32'h1);

        for (int t = 0; t < 6; t++) begin
            run_vector(tbl[t].sc, 0);
            check_outputs($sformatf("tbl%0d", t), tbl[t].ex);
            chk($sformatf("tbl%0d_latency", t), {31'h0, latency >= 0 && latency <= 2 * N + 2 * L + 3}, 32'h1);
        end

        // Single large score: dominant first output, equal remainder, input blocked while busy.
        v3 = {16'h0400, 16'h0000, 16'h0000, 16'h0000};
        e3 = model(v3);
        run_vector(v3, 0);
        check_outputs("s3", e3);
        chk("s3_busy", {31'h0, sready_bad}, 32'h0);
        if (got_q.size() == N) begin
            chk("s3_first_gt", {31'h0, got_q[0] > got_q[1]}, 32'h1);
            chk("s3_rest_eq", {31'h0, got_q[1] == got_q[2] && got_q[2] == got_q[3]}, 32'h1);
        end

        run_vector(zeros, 1);
        check_outputs("stall", {4{16'h0100}});

        load_only({4{16'h0300}});
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("midrst_quiet", {29'h0, s_ready, m_valid, o_ru_valid}, 32'h0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("midrst_s_ready", {31'h0, s_ready}, 32'h1);
        run_vector(zeros, 0);
        check_outputs("midrst", {4{16'h0100}});

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) rv[i] = 16'($urandom_range(0, 8192)) - 16'd4096;
            ev = model(rv);
            run_vector(rv, 2);
            check_outputs($sformatf("rnd%0d", r), ev);
        end

`ifdef SOFTMAX_CTRL_PERF_EN
        run_vector(zeros, 0);
        @(negedge i_clk);
        cyc1 = o_cycles;
        run_vector({4{16'h0800}}, 0);
        @(negedge i_clk);
        cyc2 = o_cycles;
        chk("perf_nonzero", {31'h0, cyc1 != 16'h0000}, 32'h1);
        chk("perf_equal", {16'h0, cyc2}, {16'h0, cyc1});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
